// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan decoder: glyph patterns ({g,f,e,d,c,b,a}, active-low),
// special nibbles and the capture FSM state encoding.
package seg_scan_pkg;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BLANK_NIB = 4'hA;
    localparam logic [3:0] ERR_NIB   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_HOLD
    } state_t;
endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational glyph decoder: active-low segment pattern -> BCD nibble plus an undecodable flag.
module seg7_to_bcd
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nib_o,
    output logic       err_o
);
    always_comb begin
        nib_o = ERR_NIB;
        err_o = 1'b0;
        case (seg_i)
            SEG_0:     nib_o = 4'd0;
            SEG_1:     nib_o = 4'd1;
            SEG_2:     nib_o = 4'd2;
            SEG_3:     nib_o = 4'd3;
            SEG_4:     nib_o = 4'd4;
            SEG_5:     nib_o = 4'd5;
            SEG_6:     nib_o = 4'd6;
            SEG_7:     nib_o = 4'd7;
            SEG_8:     nib_o = 4'd8;
            SEG_9:     nib_o = 4'd9;
            SEG_BLANK: nib_o = BLANK_NIB;
            default:   err_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// Readback of the multiplexed 4-digit seven-segment bus: samples each settled digit, assembles frames.
// Optional BCD->binary converter is built when BIN_OUT_EN is defined.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int BLANK_TIMEOUT = 2_500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        blanked,
    output logic        digit_err,
    output logic        glitch_err
`ifdef BIN_OUT_EN
    ,
    output logic [13:0] bin_value,
    output logic        bin_valid
`endif
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int BW = $clog2(BLANK_TIMEOUT + 1);

    logic [3:0]      an_s1_q, an_s2_q, an_prev_q;
    logic [6:0]      seg_s1_q, seg_s2_q, seg_prev_q;
    state_t          state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [3:0][3:0] slots_q, slots_n;
    logic [3:0]      mask_q, mask_n;
    logic            ferr_q, ferr_n;
    logic [15:0]     value_q;
    logic            fv_q, derr_q, glitch_q, blanked_q;
    logic [BW-1:0]   bcnt_q;
    logic [3:0]      dec_nib;
    logic            dec_err, change, capture, onehot, frame_done;
    logic [1:0]      idx;

    seg7_to_bcd u_dec (.seg_i(seg_s2_q), .nib_o(dec_nib), .err_o(dec_err));

    assign change  = {an_s2_q, seg_s2_q} != {an_prev_q, seg_prev_q};
    assign capture = (state_q == ST_CAPTURE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (change) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (change)
                    cnt_d = '0;
                else if (cnt_q == SW'(SETTLE_CYCLES - 1))
                    state_d = (an_s2_q == 4'hF) ? ST_IDLE : ST_CAPTURE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            ST_CAPTURE: state_d = ST_HOLD;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Next frame contents as they stand after this cycle's capture, so completion lands one cycle later.
    always_comb begin
        onehot  = 1'b1;
        idx     = 2'd0;
        slots_n = slots_q;
        mask_n  = mask_q;
        ferr_n  = ferr_q;
        case (an_s2_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: onehot = 1'b0;
        endcase
        if (capture && onehot) begin
            slots_n[idx] = dec_nib;
            mask_n[idx]  = 1'b1;
            ferr_n       = ferr_q | dec_err;
        end
    end

    assign frame_done = capture && onehot && (mask_n == 4'hF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_s1_q    <= 4'hF;
            an_s2_q    <= 4'hF;
            an_prev_q  <= 4'hF;
            seg_s1_q   <= 7'h7F;
            seg_s2_q   <= 7'h7F;
            seg_prev_q <= 7'h7F;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            slots_q    <= '0;
            mask_q     <= '0;
            ferr_q     <= 1'b0;
            value_q    <= '0;
            fv_q       <= 1'b0;
            derr_q     <= 1'b0;
            glitch_q   <= 1'b0;
            blanked_q  <= 1'b0;
            bcnt_q     <= '0;
        end else begin
            an_s1_q    <= an;
            an_s2_q    <= an_s1_q;
            an_prev_q  <= an_s2_q;
            seg_s1_q   <= seg;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slots_q    <= slots_n;
            fv_q       <= frame_done;
            glitch_q   <= capture && !onehot;
            if (frame_done) begin
                value_q <= slots_n;
                derr_q  <= ferr_n;
                mask_q  <= '0;
                ferr_q  <= 1'b0;
            end else begin
                mask_q  <= mask_n;
                ferr_q  <= ferr_n;
            end
            // Dark-display timer is sticky until a real digit is captured again.
            if (capture && onehot) begin
                bcnt_q    <= '0;
                blanked_q <= 1'b0;
            end else if (an_s2_q == 4'hF && bcnt_q != BW'(BLANK_TIMEOUT)) begin
                bcnt_q <= bcnt_q + 1'b1;
                if (bcnt_q == BW'(BLANK_TIMEOUT - 1))
                    blanked_q <= 1'b1;
            end
        end
    end

    assign value       = value_q;
    assign frame_valid = fv_q;
    assign digit_err   = derr_q;
    assign glitch_err  = glitch_q;
    assign blanked     = blanked_q;

`ifdef BIN_OUT_EN
    function automatic logic has_non_bcd(input logic [15:0] v);
        return (v[15:12] > 4'd9) || (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    logic [15:0] conv_q;
    logic [13:0] acc_q, acc_n, bin_q;
    logic [1:0]  step_q;
    logic        busy_q, bad_q, bv_q;

    assign acc_n = acc_q * 14'd10 + {10'd0, conv_q[15:12]};

    // Loaded on the completing edge itself so the result lands four cycles after frame_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conv_q <= '0;
            acc_q  <= '0;
            bin_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
            bad_q  <= 1'b0;
            bv_q   <= 1'b0;
        end else begin
            bv_q <= 1'b0;
            if (frame_done) begin
                conv_q <= slots_n;
                acc_q  <= '0;
                step_q <= '0;
                busy_q <= 1'b1;
                bad_q  <= has_non_bcd(slots_n);
            end else if (busy_q) begin
                acc_q  <= acc_n;
                conv_q <= {conv_q[11:0], 4'h0};
                step_q <= step_q + 1'b1;
                if (step_q == 2'd3) begin
                    busy_q <= 1'b0;
                    bv_q   <= 1'b1;
                    bin_q  <= bad_q ? 14'd0 : acc_n;
                end
            end
        end
    end

    assign bin_value = bin_q;
    assign bin_valid = bv_q;
`endif
endmodule
